// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall, bubble, flush and PC-redirect sequencing for the RISC-V
//            fetch/decode/execute pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_wb_i,
    input  logic        ex_is_load_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_redirect_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic        ex_hold_o,
    output logic        pc_sel_o,
    output logic [31:0] pc_redirect_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic        mem_err_o
);

    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam int RST_W  = ($clog2(RESET_CYCLES + 1) > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] C_MEM_TIMEOUT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [RST_W-1:0]  C_RST_LAST    = RST_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [15:0]       r_stall_cnt;
    logic              r_mem_err;

    logic w_mem_stall;
    logic w_redirect;
    logic w_load_use;
    logic w_timeout;

    assign w_mem_stall = ex_valid_i & mem_req_i & ~mem_ready_i;
    assign w_redirect  = ex_valid_i & ex_redirect_i;
    assign w_load_use  = ex_valid_i & ex_is_load_i & ex_wb_i & (ex_rd_addr_i != 5'd0) & id_valid_i &
                         ((id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                          (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));
    assign w_timeout   = ~mem_ready_i & (r_wait_cnt >= C_MEM_TIMEOUT);

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_hold_o      = 1'b0;
        pc_sel_o       = 1'b0;
        pc_redirect_o  = 32'd0;
        case (r_state)
            ST_RESET_HOLD: begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
            ST_RUN: begin
                if (w_mem_stall) begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    ex_hold_o     = 1'b1;
                end else if (w_redirect) begin
                    pc_sel_o       = 1'b1;
                    pc_redirect_o  = ex_redirect_addr_i;
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else if (w_load_use) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Completion and timeout both release the pipeline in the same cycle.
                if (!mem_ready_i && !w_timeout) begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    ex_hold_o     = 1'b1;
                end
            end
            ST_FLUSH: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                if (w_redirect) begin
                    pc_sel_o      = 1'b1;
                    pc_redirect_o = ex_redirect_addr_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_HOLD;
            r_wait_cnt  <= '0;
            r_rst_cnt   <= '0;
            r_stall_cnt <= 16'd0;
            r_mem_err   <= 1'b0;
        end else begin
            if (pc_stall_o && (r_state != ST_RESET_HOLD) && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            case (r_state)
                ST_RESET_HOLD: begin
                    if (r_rst_cnt == C_RST_LAST)
                        r_state <= ST_RUN;
                    else
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end else if (w_redirect) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready_i) begin
                        r_state <= ST_RUN;
                    end else if (w_timeout) begin
                        r_mem_err <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!w_redirect)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RESET_HOLD;
            endcase
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign mem_err_o   = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_uses_rs1_i;
    logic        id_uses_rs2_i;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_wb_i;
    logic        ex_is_load_i;
    logic        ex_redirect_i;
    logic [31:0] ex_redirect_addr_i;
    logic        mem_req_i;
    logic        mem_ready_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_bubble_o;
    logic        ex_hold_o;
    logic        pc_sel_o;
    logic [31:0] pc_redirect_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic        mem_err_o;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, pc_sel
    logic [5:0] ctrl;
    assign ctrl = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_hold_o, pc_sel_o};

    localparam logic [5:0] C_HOLD  = 6'b111100;
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110100;
    localparam logic [5:0] C_REDIR = 6'b001101;
    localparam logic [5:0] C_FLUSH = 6'b001100;
    localparam logic [5:0] C_MEM   = 6'b110010;

    pipe_hazard_ctrl #(
        .RESET_CYCLES (2),
        .MEM_TIMEOUT  (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_valid_i         (id_valid_i),
        .id_rs1_addr_i      (id_rs1_addr_i),
        .id_rs2_addr_i      (id_rs2_addr_i),
        .id_uses_rs1_i      (id_uses_rs1_i),
        .id_uses_rs2_i      (id_uses_rs2_i),
        .ex_valid_i         (ex_valid_i),
        .ex_rd_addr_i       (ex_rd_addr_i),
        .ex_wb_i            (ex_wb_i),
        .ex_is_load_i       (ex_is_load_i),
        .ex_redirect_i      (ex_redirect_i),
        .ex_redirect_addr_i (ex_redirect_addr_i),
        .mem_req_i          (mem_req_i),
        .mem_ready_i        (mem_ready_i),
        .pc_stall_o         (pc_stall_o),
        .if_id_stall_o      (if_id_stall_o),
        .if_id_flush_o      (if_id_flush_o),
        .id_ex_bubble_o     (id_ex_bubble_o),
        .ex_hold_o          (ex_hold_o),
        .pc_sel_o           (pc_sel_o),
        .pc_redirect_o      (pc_redirect_o),
        .state_o            (state_o),
        .stall_cnt_o        (stall_cnt_o),
        .mem_err_o          (mem_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0;
        ex_valid_i = 0; ex_rd_addr_i = 0; ex_wb_i = 0; ex_is_load_i = 0;
        ex_redirect_i = 0; ex_redirect_addr_i = 0;
        mem_req_i = 0; mem_ready_i = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_valid_i = 1; ex_is_load_i = 1; ex_wb_i = 1; ex_rd_addr_i = rd;
        id_valid_i = 1; id_uses_rs1_i = 1; id_uses_rs2_i = 1;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        repeat (3) tick();
        checks++;
        if (ctrl !== C_HOLD || state_o !== 2'd0 || pc_redirect_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_asserted ctrl=%b state=%0d redir=%h want ctrl=%b state=0 redir=0",
                     ctrl, state_o, pc_redirect_o, C_HOLD);
        end
        checks++;
        if (stall_cnt_o !== 16'd0 || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters stall_cnt=%0d mem_err=%b want 0 0", stall_cnt_o, mem_err_o);
        end
        rst_n = 1;
        #1;
        checks++;
        if (state_o !== 2'd0 || ctrl !== C_HOLD) begin
            errors++;
            $display("FAIL hold_cycle1 state=%0d ctrl=%b want 0 %b", state_o, ctrl, C_HOLD);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || ctrl !== C_HOLD) begin
            errors++;
            $display("FAIL hold_cycle2 state=%0d ctrl=%b want 0 %b", state_o, ctrl, C_HOLD);
        end
        tick();
        checks++;
        if (state_o !== 2'd1 || ctrl !== C_IDLE || stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL run_after_reset state=%0d ctrl=%b cnt=%0d want 1 %b 0",
                     state_o, ctrl, stall_cnt_o, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        set_load_use(5'd5, 5'd3, 5'd5);
        #1;
        checks++;
        if (ctrl !== C_LU || state_o !== 2'd1) begin
            errors++;
            $display("FAIL load_use_rs2 ctrl=%b state=%0d want %b 1", ctrl, state_o, C_LU);
        end
        tick();
        exp_cnt++;
        set_idle();
        #1;
        checks++;
        if (ctrl !== C_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL load_use_one_cycle ctrl=%b cnt=%0d want %b %0d", ctrl, stall_cnt_o, C_IDLE, exp_cnt);
        end
        set_load_use(5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL load_use_x0 ctrl=%b want %b", ctrl, C_IDLE);
        end
        set_load_use(5'd7, 5'd7, 5'd9);
        #1;
        checks++;
        if (ctrl !== C_LU) begin
            errors++;
            $display("FAIL load_use_rs1 ctrl=%b want %b", ctrl, C_LU);
        end
        id_uses_rs1_i = 0;
        #1;
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL load_use_unused_src ctrl=%b want %b", ctrl, C_IDLE);
        end
        set_load_use(5'd7, 5'd7, 5'd9);
        ex_is_load_i = 0;
        #1;
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL load_use_not_load ctrl=%b want %b", ctrl, C_IDLE);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (stall_cnt_o !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL load_use_cnt stall_cnt=%0d want %0d", stall_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_redirect();
        set_load_use(5'd5, 5'd5, 5'd5);
        ex_redirect_i = 1;
        ex_redirect_addr_i = 32'h1000_0040;
        #1;
        checks++;
        if (ctrl !== C_REDIR || pc_redirect_o !== 32'h1000_0040) begin
            errors++;
            $display("FAIL redirect_detect ctrl=%b addr=%h want %b 10000040", ctrl, pc_redirect_o, C_REDIR);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (state_o !== 2'd3 || ctrl !== C_FLUSH || pc_redirect_o !== 32'd0) begin
            errors++;
            $display("FAIL redirect_flush state=%0d ctrl=%b addr=%h want 3 %b 0", state_o, ctrl, pc_redirect_o, C_FLUSH);
        end
        tick();
        checks++;
        if (state_o !== 2'd1 || ctrl !== C_IDLE || stall_cnt_o !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL redirect_done state=%0d ctrl=%b cnt=%0d want 1 %b %0d",
                     state_o, ctrl, stall_cnt_o, C_IDLE, exp_cnt);
        end
    endtask

    task automatic test_flush_redirect();
        ex_valid_i = 1; ex_redirect_i = 1; ex_redirect_addr_i = 32'h0000_0100;
        tick();
        ex_redirect_addr_i = 32'h0000_0200;
        #1;
        checks++;
        if (state_o !== 2'd3 || ctrl !== C_REDIR || pc_redirect_o !== 32'h0000_0200) begin
            errors++;
            $display("FAIL flush_redirect state=%0d ctrl=%b addr=%h want 3 %b 00000200",
                     state_o, ctrl, pc_redirect_o, C_REDIR);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (state_o !== 2'd3 || ctrl !== C_FLUSH) begin
            errors++;
            $display("FAIL flush_stay state=%0d ctrl=%b want 3 %b", state_o, ctrl, C_FLUSH);
        end
        tick();
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL flush_exit state=%0d want 1", state_o);
        end
    endtask

    task automatic test_mem_wait();
        ex_valid_i = 1; mem_req_i = 1; mem_ready_i = 1;
        #1;
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL mem_ready_same_cycle ctrl=%b want %b", ctrl, C_IDLE);
        end
        mem_ready_i = 0;
        #1;
        checks++;
        if (ctrl !== C_MEM || state_o !== 2'd1) begin
            errors++;
            $display("FAIL mem_detect ctrl=%b state=%0d want %b 1", ctrl, state_o, C_MEM);
        end
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            ex_redirect_i = (i == 2);
            ex_redirect_addr_i = 32'hDEAD_0000;
            #1;
            checks++;
            if (state_o !== 2'd2 || ctrl !== C_MEM || pc_redirect_o !== 32'd0) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d state=%0d ctrl=%b addr=%h want 2 %b 0",
                         i, state_o, ctrl, pc_redirect_o, C_MEM);
            end
            exp_cnt++;
        end
        tick();
        ex_redirect_i = 0;
        mem_ready_i = 1;
        #1;
        checks++;
        if (state_o !== 2'd2 || ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL mem_ready_release state=%0d ctrl=%b want 2 %b", state_o, ctrl, C_IDLE);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (state_o !== 2'd1 || stall_cnt_o !== 16'(exp_cnt) || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL mem_done state=%0d cnt=%0d err=%b want 1 %0d 0", state_o, stall_cnt_o, mem_err_o, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        ex_valid_i = 1; mem_req_i = 1; mem_ready_i = 0;
        #1;
        exp_cnt++;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (state_o !== 2'd2 || ctrl !== C_MEM) begin
                errors++;
                $display("FAIL timeout_wait%0d state=%0d ctrl=%b want 2 %b", i, state_o, ctrl, C_MEM);
            end
            exp_cnt++;
        end
        tick();
        checks++;
        if (state_o !== 2'd2 || ctrl !== C_IDLE || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release state=%0d ctrl=%b err=%b want 2 %b 0", state_o, ctrl, mem_err_o, C_IDLE);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (state_o !== 2'd1 || mem_err_o !== 1'b1 || stall_cnt_o !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL timeout_err state=%0d err=%b cnt=%0d want 1 1 %0d", state_o, mem_err_o, stall_cnt_o, exp_cnt);
        end
        repeat (3) tick();
        checks++;
        if (mem_err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky err=%b want 1", mem_err_o);
        end
    endtask

    task automatic test_async_reset();
        ex_valid_i = 1; mem_req_i = 1; mem_ready_i = 0;
        tick();
        tick();
        checks++;
        if (state_o !== 2'd2 || ex_hold_o !== 1'b1) begin
            errors++;
            $display("FAIL async_pre state=%0d ex_hold=%b want 2 1", state_o, ex_hold_o);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (state_o !== 2'd0 || ex_hold_o !== 1'b0 || ctrl !== C_HOLD) begin
            errors++;
            $display("FAIL async_state state=%0d ctrl=%b want 0 %b", state_o, ctrl, C_HOLD);
        end
        checks++;
        if (stall_cnt_o !== 16'd0 || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_counters cnt=%0d err=%b want 0 0", stall_cnt_o, mem_err_o);
        end
        tick();
        set_idle();
        rst_n = 1;
        tick();
        tick();
        checks++;
        if (state_o !== 2'd1 || ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL async_recover state=%0d ctrl=%b want 1 %b", state_o, ctrl, C_IDLE);
        end
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_flush_redirect();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
